rle_encoder: RTL



---
 rtl/acsp_pkg.sv | 16 +
 rtl/rle_encoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/acsp_pkg.sv
// Shared constants and types for the acquisition sample path.
// Used by rle_encoder for its state encoding.
package acsp_pkg;

  localparam int SAMPLE_WIDTH = 8;
  localparam int RLE_FLAG_BIT = SAMPLE_WIDTH - 1;

  typedef enum logic [1:0] {
    EMPTY,
    TRACK,
    FLUSH
  } rle_state_t;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/rle_encoder.sv
// Run-length encoder between the sampler and the sample FIFO (SUMP-style MSB flag words).
// Optional macro RLE_STATS_EN adds words_in/words_out counters for compression-ratio readout.
module rle_encoder #(
  parameter int SAMPLE_WIDTH = acsp_pkg::SAMPLE_WIDTH,
  parameter int CNT_MAX      = 2**(SAMPLE_WIDTH-1) - 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rle_en,
  input  logic                    flush,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    flush_busy
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]             words_in,
  output logic [31:0]             words_out
`endif
);
  import acsp_pkg::*;

  typedef logic [SAMPLE_WIDTH-1:0] word_t;
  typedef logic [SAMPLE_WIDTH-2:0] count_t;

  localparam count_t CNT_LIM = count_t'(CNT_MAX);

  rle_state_t state_q, state_d;
  logic       mode_q, mode_d;          // 1 = RLE, 0 = passthrough
  word_t      cur_q, cur_d;
  count_t     count_q, count_d;
  logic       pend_v_q, pend_v_d;
  word_t      pend_q, pend_d;

  logic  gen0_v, gen1_v, out_v, overflow;
  word_t gen0, gen1, out_word, masked;

  function automatic word_t count_word(input count_t c);
    return {1'b1, c};
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    masked   = {1'b0, data_in[SAMPLE_WIDTH-2:0]};
    state_d  = state_q;
    mode_d   = mode_q;
    cur_d    = cur_q;
    count_d  = count_q;
    gen0_v   = 1'b0;
    gen0     = '0;
    gen1_v   = 1'b0;
    gen1     = '0;

    unique case (state_q)
      EMPTY: begin
        if (valid_in) begin
          mode_d  = rle_en;
          state_d = TRACK;
          count_d = '0;
          cur_d   = masked;
          gen0_v  = 1'b1;
          gen0    = rle_en ? masked : data_in;
        end
      end
      TRACK: begin
        if (valid_in) begin
          if (!mode_q) begin
            gen0_v = 1'b1;
            gen0   = data_in;
          end else if (masked == cur_q) begin
            if (count_q + count_t'(1) == CNT_LIM) begin
              gen0_v  = 1'b1;
              gen0    = count_word(CNT_LIM);
              count_d = '0;
            end else begin
              count_d = count_q + count_t'(1);
            end
          end else if (count_q == '0) begin
            gen0_v = 1'b1;
            gen0   = masked;
            cur_d  = masked;
          end else begin
            // Run ends: count word goes out first, the new value follows.
            gen0_v  = 1'b1;
            gen0    = count_word(count_q);
            gen1_v  = 1'b1;
            gen1    = masked;
            cur_d   = masked;
            count_d = '0;
          end
        end
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        // Pending word drains through the output stage; the count follows next.
        if (!pend_v_q && count_q != '0) begin
          gen0_v  = 1'b1;
          gen0    = count_word(count_q);
          count_d = '0;
        end
        state_d = (pend_v_q && count_q != '0) ? FLUSH : EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    // Single output slot: the parked word always wins over fresh words.
    if (pend_v_q) begin
      out_v    = 1'b1;
      out_word = pend_q;
      pend_v_d = gen0_v;
      pend_d   = gen0;
      overflow = gen1_v;
    end else begin
      out_v    = gen0_v;
      out_word = gen0;
      pend_v_d = gen1_v;
      pend_d   = gen1;
      overflow = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= EMPTY;
      mode_q    <= 1'b0;
      cur_q     <= '0;
      count_q   <= '0;
      pend_v_q  <= 1'b0;
      pend_q    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cur_q     <= cur_d;
      count_q   <= count_d;
      pend_v_q  <= pend_v_d;
      pend_q    <= pend_d;
      valid_out <= out_v;
      if (out_v) data_out <= out_word;
    end
  end

  assign flush_busy = (state_q == FLUSH);

  pending_no_overflow: assert property (@(posedge clock) disable iff (reset) !overflow);

`ifdef RLE_STATS_EN
  logic run_start;
  assign run_start = (state_q == EMPTY) && valid_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      words_in  <= '0;
      words_out <= '0;
    end else if (run_start) begin
      words_in  <= 32'd1;
      words_out <= 32'd1;
    end else begin
      if (valid_in && state_q != FLUSH) words_in <= words_in + 32'd1;
      if (out_v) words_out <= words_out + 32'd1;
    end
  end
`endif

endmodule
